scan_mux: RTL and testbench

SCAN_MUX -- requirements
Module: scan_mux

---
 rtl/scan_mux_if.sv | 29 ++
 rtl/scan_mux.sv | 93 +++++++++
 tb/tb_scan_mux.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/scan_mux_if.sv
// Bundle of the scan_mux data, select, handshake and status signals.
// The master drives channels and controls; the slave returns the captured word.
interface scan_mux_if #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 8
);
  localparam int unsigned SW = $clog2(N);

  logic [N*W-1:0] data_in;
  logic [SW-1:0]  sel;
  logic           mode;
  logic           en;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           scan_done;
  logic           sel_err;

  modport master (
    output data_in, sel, mode, en, out_ready,
    input  out_data, out_ch, out_valid, scan_done, sel_err
  );

  modport slave (
    input  data_in, sel, mode, en, out_ready,
    output out_data, out_ch, out_valid, scan_done, sel_err
  );
endinterface

// File: rtl/scan_mux.sv
// N-channel capture mux with manual select or auto-scan, feeding a one-word
// valid/ready output register. All outputs come straight from flops.
module scan_mux #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 8
) (
  input logic        clk,
  input logic        rst,
  scan_mux_if.slave  bus
);
  localparam int unsigned SW = $clog2(N);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e         state_q, state_d;
  logic           mode_q, mode_d;
  logic [SW-1:0]  ptr_q, ptr_d;
  logic [SW-1:0]  out_ch_q, out_ch_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           scan_done_q, scan_done_d;
  logic           sel_err_q, sel_err_d;

  logic [W-1:0]   chans [N];
  logic [SW-1:0]  ptr_eff;
  logic           slot, accept, sel_ok;

  always_comb begin
    for (int k = 0; k < int'(N); k++) begin
      chans[k] = bus.data_in[k*W +: W];
    end
  end

  // A rising mode edge restarts the scan at channel 0 in the same cycle.
  assign ptr_eff = (bus.mode && !mode_q) ? '0 : ptr_q;
  assign accept  = (state_q == StFull) && bus.out_ready;
  assign slot    = bus.en && ((state_q == StEmpty) || bus.out_ready);
  assign sel_ok  = (32'(bus.sel) < N);

  always_comb begin
    state_d     = state_q;
    mode_d      = bus.mode;
    ptr_d       = ptr_eff;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    scan_done_d = 1'b0;
    sel_err_d   = 1'b0;
    if (slot) begin
      if (bus.mode) begin
        out_data_d  = chans[ptr_eff];
        out_ch_d    = ptr_eff;
        state_d     = StFull;
        scan_done_d = (ptr_eff == SW'(N - 1));
        ptr_d       = (ptr_eff == SW'(N - 1)) ? '0 : ptr_eff + SW'(1);
      end else if (sel_ok) begin
        out_data_d = chans[bus.sel];
        out_ch_d   = bus.sel;
        state_d    = StFull;
      end else begin
        // Rejected select still lets an accepted word drain.
        sel_err_d = 1'b1;
        if (accept) state_d = StEmpty;
      end
    end else if (accept) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      mode_q      <= 1'b0;
      ptr_q       <= '0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      scan_done_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      ptr_q       <= ptr_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      scan_done_q <= scan_done_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = (state_q == StFull);
  assign bus.scan_done = scan_done_q;
  assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: a 32x8 instance for the main features and a
// 20x8 instance for out-of-range select handling.
module tb_scan_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  scan_mux_if #(.N(32), .W(8)) b1 ();
  scan_mux_if #(.N(20), .W(8)) b2 ();

  scan_mux #(.N(32), .W(8)) u1 (.clk(clk), .rst(rst), .bus(b1));
  scan_mux #(.N(20), .W(8)) u2 (.clk(clk), .rst(rst), .bus(b2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill1(input logic [7:0] base);
    for (int k = 0; k < 32; k++) b1.data_in[k*8 +: 8] = 8'(k) + base;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (b1.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", b1.out_valid); end
    n_cmp++; if (b1.out_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", b1.out_data); end
    n_cmp++; if (b1.out_ch !== 5'd0) begin n_err++; $display("FAIL reset_ch got %0d want 0", b1.out_ch); end
    n_cmp++; if ({b1.scan_done, b1.sel_err} !== 2'b00) begin n_err++; $display("FAIL reset_pulses got %b want 00", {b1.scan_done, b1.sel_err}); end
    rst = 1'b0;
  endtask

  task automatic test_manual();
    fill1(8'h40);
    b1.mode = 1'b0; b1.sel = 5'd17; b1.en = 1'b1; b1.out_ready = 1'b1;
    step();
    b1.en = 1'b0;
    n_cmp++; if (b1.out_data !== 8'h51) begin n_err++; $display("FAIL manual_data got %h want 51", b1.out_data); end
    n_cmp++; if (b1.out_ch !== 5'd17) begin n_err++; $display("FAIL manual_ch got %0d want 17", b1.out_ch); end
    n_cmp++; if (b1.out_valid !== 1'b1) begin n_err++; $display("FAIL manual_valid got %b want 1", b1.out_valid); end
    n_cmp++; if (b1.sel_err !== 1'b0) begin n_err++; $display("FAIL manual_selerr got %b want 0", b1.sel_err); end
    step();
    n_cmp++; if (b1.out_valid !== 1'b0) begin n_err++; $display("FAIL manual_drain got %b want 0", b1.out_valid); end
    n_cmp++; if (b1.out_data !== 8'h51) begin n_err++; $display("FAIL manual_hold got %h want 51", b1.out_data); end
  endtask

  task automatic test_backpressure();
    b1.out_ready = 1'b0; b1.sel = 5'd3; b1.en = 1'b1;
    step();
    fill1(8'h80);
    b1.sel = 5'd9;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (b1.out_data !== 8'h43 || b1.out_ch !== 5'd3 || b1.out_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_hold%0d got %h/%0d/%b want 43/3/1", i, b1.out_data, b1.out_ch, b1.out_valid);
      end
    end
    b1.out_ready = 1'b1;
    step();
    b1.en = 1'b0;
    n_cmp++; if (b1.out_ch !== 5'd9 || b1.out_data !== 8'h89) begin n_err++; $display("FAIL bp_next got %0d/%h want 9/89", b1.out_ch, b1.out_data); end
    n_cmp++; if (b1.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid got %b want 1", b1.out_valid); end
    step();
  endtask

  task automatic test_scan_wrap();
    int dones = 0;
    logic [4:0] ch;
    b1.mode = 1'b1; b1.en = 1'b1; b1.out_ready = 1'b1; b1.sel = 5'd31;
    for (int i = 0; i < 34; i++) begin
      step();
      ch = 5'(i % 32);
      if (b1.scan_done) dones++;
      n_cmp++; if (b1.out_ch !== ch || b1.out_data !== 8'(ch) + 8'h80 || b1.out_valid !== 1'b1) begin
        n_err++; $display("FAIL scan_word%0d got %0d/%h/%b want %0d/%h/1", i, b1.out_ch, b1.out_data, b1.out_valid, ch, 8'(ch) + 8'h80);
      end
      n_cmp++; if (b1.scan_done !== (ch == 5'd31) || b1.sel_err !== 1'b0) begin
        n_err++; $display("FAIL scan_flags%0d got done=%b err=%b want done=%b err=0", i, b1.scan_done, b1.sel_err, ch == 5'd31);
      end
    end
    n_cmp++; if (dones != 1) begin n_err++; $display("FAIL scan_done_count got %0d want 1", dones); end
  endtask

  task automatic test_mode_reentry();
    int guard = 0;
    while (b1.out_ch !== 5'd12 && guard < 40) begin
      step();
      guard++;
    end
    n_cmp++; if (b1.out_ch !== 5'd12) begin n_err++; $display("FAIL reentry_reach got %0d want 12", b1.out_ch); end
    b1.mode = 1'b0; b1.en = 1'b0;
    step();
    step();
    b1.mode = 1'b1; b1.en = 1'b1;
    step();
    n_cmp++; if (b1.out_ch !== 5'd0 || b1.out_data !== 8'h80 || b1.out_valid !== 1'b1) begin
      n_err++; $display("FAIL reentry_word got %0d/%h/%b want 0/80/1", b1.out_ch, b1.out_data, b1.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    b1.out_ready = 1'b0; b1.en = 1'b1;
    step();
    n_cmp++; if (b1.out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got %b want 1", b1.out_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if ({b1.out_valid, b1.out_ch, b1.out_data, b1.scan_done, b1.sel_err} !== 16'h0) begin
      n_err++; $display("FAIL rstmid_zero got v=%b ch=%0d d=%h sd=%b se=%b want all 0", b1.out_valid, b1.out_ch, b1.out_data, b1.scan_done, b1.sel_err);
    end
    b1.out_ready = 1'b1;
    step();
    b1.en = 1'b0;
    n_cmp++; if (b1.out_ch !== 5'd0 || b1.out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_scan got %0d/%b want 0/1", b1.out_ch, b1.out_valid); end
    step();
  endtask

  task automatic test_sel_err();
    for (int k = 0; k < 20; k++) b2.data_in[k*8 +: 8] = 8'(k) + 8'h10;
    b2.mode = 1'b0; b2.sel = 5'd25; b2.en = 1'b1; b2.out_ready = 1'b1;
    step();
    b2.en = 1'b0;
    n_cmp++; if (b2.sel_err !== 1'b1 || b2.out_valid !== 1'b0) begin n_err++; $display("FAIL selerr_pulse got err=%b v=%b want 1/0", b2.sel_err, b2.out_valid); end
    step();
    n_cmp++; if (b2.sel_err !== 1'b0 || b2.out_valid !== 1'b0) begin n_err++; $display("FAIL selerr_clear got err=%b v=%b want 0/0", b2.sel_err, b2.out_valid); end
    b2.sel = 5'd19; b2.en = 1'b1;
    step();
    n_cmp++; if (b2.out_ch !== 5'd19 || b2.out_data !== 8'h23 || b2.out_valid !== 1'b1) begin
      n_err++; $display("FAIL selerr_edge got %0d/%h/%b want 19/23/1", b2.out_ch, b2.out_data, b2.out_valid);
    end
    b2.sel = 5'd25;
    step();
    b2.en = 1'b0;
    n_cmp++; if (b2.sel_err !== 1'b1 || b2.out_valid !== 1'b0 || b2.out_ch !== 5'd19 || b2.out_data !== 8'h23) begin
      n_err++; $display("FAIL selerr_drain got err=%b v=%b ch=%0d d=%h want 1/0/19/23", b2.sel_err, b2.out_valid, b2.out_ch, b2.out_data);
    end
  endtask

  initial begin
    b1.data_in = '0; b1.sel = '0; b1.mode = 1'b0; b1.en = 1'b0; b1.out_ready = 1'b0;
    b2.data_in = '0; b2.sel = '0; b2.mode = 1'b0; b2.en = 1'b0; b2.out_ready = 1'b0;
    test_reset();
    test_manual();
    test_backpressure();
    test_scan_wrap();
    test_mode_reentry();
    test_reset_mid();
    test_sel_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after 200us");
    $fatal(1, "timeout");
  end
endmodule
